// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Brief    : Shared types and constants for the MIPS pipeline front end.
// Revision : 1.0
// ============================================================================
package mips_pkg;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        SQUASH = 2'd2
    } if_state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    function automatic logic [31:0] branch_target(input logic [31:0] pc_plus4,
                                                  input logic [15:0] imm);
        return pc_plus4 + {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/if_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : if_stage_if
// Brief    : Decode controls, instruction-memory bus and IF/ID outputs.
// Revision : 1.0
// ============================================================================
interface if_stage_if;

    logic        stall_in;
    logic        br_taken_in;
    logic        flush_in;
    logic        imem_req_out;
    logic [31:0] imem_addr_out;
    logic [31:0] imem_rdata_in;
    logic        imem_ready_in;
    logic [31:0] instruction_out;
    logic [31:0] pc_plus4_out;
    logic        valid_out;

    modport master (
        input  stall_in, br_taken_in, flush_in, imem_rdata_in, imem_ready_in,
        output imem_req_out, imem_addr_out, instruction_out, pc_plus4_out, valid_out
    );

    modport slave (
        output stall_in, br_taken_in, flush_in, imem_rdata_in, imem_ready_in,
        input  imem_req_out, imem_addr_out, instruction_out, pc_plus4_out, valid_out
    );

endinterface
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
// Module   : if_id_reg
// Brief    : IF/ID pipeline register with load, bubble and hold controls.
// Revision : 1.0
// ============================================================================
module if_id_reg
    import mips_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        load_i,
    input  wire logic        bubble_i,
    input  wire logic [31:0] instr_i,
    input  wire logic [31:0] pc_plus4_i,
    output logic      [31:0] instr_o,
    output logic      [31:0] pc_plus4_o,
    output logic             valid_o
);

    logic [31:0] instr_q;
    logic [31:0] pc_plus4_q;
    logic        valid_q;

    // A bubble keeps pc_plus4 so decode still sees the last real PC+4.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q    <= NOP_INSTR;
            pc_plus4_q <= 32'h0;
            valid_q    <= 1'b0;
        end else if (bubble_i) begin
            instr_q    <= NOP_INSTR;
            valid_q    <= 1'b0;
        end else if (load_i) begin
            instr_q    <= instr_i;
            pc_plus4_q <= pc_plus4_i;
            valid_q    <= 1'b1;
        end
    end

    assign instr_o    = instr_q;
    assign pc_plus4_o = pc_plus4_q;
    assign valid_o    = valid_q;

endmodule
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_stage
// Brief    : MIPS instruction fetch: PC, variable-latency imem handshake, IF/ID.
// Revision : 1.0
// ============================================================================
module if_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  wire logic clk,
    input  wire logic rst,
    if_stage_if.master bus
);

    localparam logic [1:0] ST_FETCH  = FETCH;
    localparam logic [1:0] ST_HOLD   = HOLD;
    localparam logic [1:0] ST_SQUASH = SQUASH;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] tgt_q, tgt_d;

    logic        ifid_load;
    logic        ifid_bubble;
    logic [31:0] ifid_instr;
    logic [31:0] pc_plus4;
    logic [31:0] br_target;
    logic        br_take;
    logic        flush_take;

    assign pc_plus4   = pc_q + 32'd4;
    assign br_target  = branch_target(bus.pc_plus4_out, bus.instruction_out[15:0]);
    assign br_take    = bus.valid_out & ~bus.stall_in & bus.br_taken_in;
    assign flush_take = bus.valid_out & ~bus.stall_in & bus.flush_in;

    assign bus.imem_req_out  = ~rst & ((state_q == ST_FETCH) | (state_q == ST_SQUASH));
    assign bus.imem_addr_out = pc_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        buf_d       = buf_q;
        tgt_d       = tgt_q;
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        ifid_instr  = buf_q;
        case (state_q)
            ST_FETCH: begin
                if (br_take) begin
                    ifid_bubble = 1'b1;
                    if (bus.imem_ready_in) begin
                        pc_d = br_target;
                    end else begin
                        // The request in flight cannot be withdrawn; park the target.
                        tgt_d   = br_target;
                        state_d = ST_SQUASH;
                    end
                end else if (bus.imem_ready_in && !bus.stall_in) begin
                    ifid_instr  = bus.imem_rdata_in;
                    ifid_load   = ~flush_take;
                    ifid_bubble = flush_take;
                    pc_d        = pc_plus4;
                end else if (bus.imem_ready_in) begin
                    buf_d   = bus.imem_rdata_in;
                    state_d = ST_HOLD;
                end else if (!bus.stall_in) begin
                    ifid_bubble = 1'b1;
                end
            end
            ST_HOLD: begin
                if (br_take) begin
                    ifid_bubble = 1'b1;
                    pc_d        = br_target;
                    state_d     = ST_FETCH;
                end else if (!bus.stall_in) begin
                    ifid_load   = ~flush_take;
                    ifid_bubble = flush_take;
                    pc_d        = pc_plus4;
                    state_d     = ST_FETCH;
                end
            end
            ST_SQUASH: begin
                ifid_bubble = 1'b1;
                if (bus.imem_ready_in) begin
                    pc_d    = tgt_q;
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            buf_q   <= 32'h0;
            tgt_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            buf_q   <= buf_d;
            tgt_q   <= tgt_d;
        end
    end

    if_id_reg u_if_id_reg (
        .clk        (clk),
        .rst        (rst),
        .load_i     (ifid_load),
        .bubble_i   (ifid_bubble),
        .instr_i    (ifid_instr),
        .pc_plus4_i (pc_plus4),
        .instr_o    (bus.instruction_out),
        .pc_plus4_o (bus.pc_plus4_out),
        .valid_o    (bus.valid_out)
    );

endmodule
`default_nettype wire
